// File: rtl/mips_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_mem_pkg
// Description : Shared encodings for the MEM-stage load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_mem_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LW  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LB  = 4'd4;
    localparam logic [3:0] OP_LBU = 4'd5;
    localparam logic [3:0] OP_SW  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SB  = 4'd8;

    localparam int ST_W = 1;
    localparam logic [ST_W-1:0] ST_IDLE = 1'b0;
    localparam logic [ST_W-1:0] ST_RMW  = 1'b1;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_e;

    localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
    localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

    function automatic mem_size_e op_size(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align_ext.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align_ext
// Description : Byte/half lane extract with sign/zero extend, and store-lane merge.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align_ext
    import mips_mem_pkg::*;
(
    input  mem_size_e   size,
    input  logic        sign_ext,
    input  logic [1:0]  lane,
    input  logic [31:0] rd_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [4:0]  w_shamt;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_mask;

    always_comb begin
        // Halves sit on 16-bit boundaries, so only the upper lane bit matters.
        w_shamt     = (size == SZ_HALF) ? {lane[1], 4'b0000} : {lane, 3'b000};
        w_byte      = rd_word[w_shamt +: 8];
        w_half      = rd_word[w_shamt +: 16];
        w_mask      = '0;
        load_data   = rd_word;
        merged_word = store_data;
        case (size)
            SZ_BYTE: begin
                load_data   = {{24{sign_ext & w_byte[7]}}, w_byte};
                w_mask      = BYTE_MASK << w_shamt;
                merged_word = (rd_word & ~w_mask) | ((store_data & BYTE_MASK) << w_shamt);
            end
            SZ_HALF: begin
                load_data   = {{16{sign_ext & w_half[15]}}, w_half};
                w_mask      = HALF_MASK << w_shamt;
                merged_word = (rd_word & ~w_mask) | ((store_data & HALF_MASK) << w_shamt);
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu
// Description : MEM-stage load/store unit with SB/SH read-modify-write.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_lsu
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_LOG2  = 5,
    parameter bit CHECK_RANGE = 1'b1
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [3:0]  ex_op,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwrite,
    output logic        stall,
    output logic [31:0] dmem_addr,
    output logic        dmem_rd_en,
    output logic        dmem_wr_en,
    output logic [31:0] dmem_wr_data,
    input  logic [31:0] dmem_rd_data,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_regwrite,
    output logic [31:0] wb_data,
    output logic        exc_misalign,
    output logic        exc_range
);

    logic [ST_W-1:0] r_state;
    logic [ST_W-1:0] w_next_state;
    logic [31:0]     r_rmw_addr;
    logic [31:0]     r_rmw_data;
    logic [4:0]      r_rmw_rd;

    mem_size_e   w_size;
    logic        w_is_load, w_is_sw, w_is_sub, w_is_mem, w_sign;
    logic        w_misalign, w_range, w_ok;
    logic [31:0] w_load_data, w_merged;

    assign w_size     = op_size(ex_op);
    assign w_is_load  = (ex_op >= OP_LW) && (ex_op <= OP_LBU);
    assign w_is_sw    = (ex_op == OP_SW);
    assign w_is_sub   = (ex_op == OP_SH) || (ex_op == OP_SB);
    assign w_is_mem   = w_is_load || w_is_sw || w_is_sub;
    assign w_sign     = (ex_op == OP_LH) || (ex_op == OP_LB);
    assign w_misalign = w_is_mem && (((w_size == SZ_WORD) && (ex_addr[1:0] != 2'b00)) ||
                                     ((w_size == SZ_HALF) && ex_addr[0]));
    assign w_range    = CHECK_RANGE && w_is_mem && ((ex_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
    assign w_ok       = !w_misalign && !w_range;

    lsu_align_ext u_align (
        .size        (w_size),
        .sign_ext    (w_sign),
        .lane        (ex_addr[1:0]),
        .rd_word     (dmem_rd_data),
        .store_data  (ex_store_data),
        .load_data   (w_load_data),
        .merged_word (w_merged)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (ex_valid && w_is_sub && w_ok) w_next_state = ST_RMW;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Memory strobes are gated by reset so an interrupted RMW never writes.
    always_comb begin
        stall        = 1'b0;
        dmem_addr    = '0;
        dmem_rd_en   = 1'b0;
        dmem_wr_en   = 1'b0;
        dmem_wr_data = '0;
        if (!reset) begin
            case (r_state)
                ST_RMW: begin
                    dmem_wr_en   = 1'b1;
                    dmem_addr    = r_rmw_addr;
                    dmem_wr_data = r_rmw_data;
                end
                default: begin
                    if (ex_valid && w_ok) begin
                        if (w_is_load || w_is_sub) begin
                            dmem_rd_en = 1'b1;
                            dmem_addr  = ex_addr;
                            stall      = w_is_sub;
                        end else if (w_is_sw) begin
                            dmem_wr_en   = 1'b1;
                            dmem_addr    = ex_addr;
                            dmem_wr_data = ex_store_data;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rmw_addr <= '0;
            r_rmw_data <= '0;
            r_rmw_rd   <= '0;
        end else if ((r_state == ST_IDLE) && stall) begin
            r_rmw_addr <= ex_addr;
            r_rmw_data <= w_merged;
            r_rmw_rd   <= ex_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_regwrite  <= 1'b0;
            wb_data      <= '0;
            exc_misalign <= 1'b0;
            exc_range    <= 1'b0;
        end else begin
            exc_misalign <= 1'b0;
            exc_range    <= 1'b0;
            if (r_state == ST_RMW) begin
                wb_valid    <= 1'b1;
                wb_regwrite <= 1'b0;
                wb_rd       <= r_rmw_rd;
                wb_data     <= r_rmw_addr;
            end else if (ex_valid && !stall) begin
                wb_valid <= 1'b1;
                wb_rd    <= ex_rd;
                if (!w_ok) begin
                    wb_regwrite  <= 1'b0;
                    wb_data      <= ex_addr;
                    exc_misalign <= w_misalign;
                    exc_range    <= w_range && !w_misalign;
                end else if (w_is_load) begin
                    wb_regwrite <= 1'b1;
                    wb_data     <= w_load_data;
                end else if (w_is_mem) begin
                    wb_regwrite <= 1'b0;
                    wb_data     <= ex_addr;
                end else begin
                    wb_regwrite <= ex_regwrite;
                    wb_data     <= ex_addr;
                end
            end else begin
                wb_valid    <= 1'b0;
                wb_regwrite <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_lsu
// Description : Self-checking bench for mem_stage_lsu against a byte-array model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_stage_lsu;

    localparam logic [3:0] T_NOP = 4'd0, T_LW = 4'd1, T_LH = 4'd2, T_LHU = 4'd3, T_LB = 4'd4,
                           T_LBU = 4'd5, T_SW = 4'd6, T_SH = 4'd7, T_SB = 4'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_regwrite;
    logic [3:0]  ex_op;
    logic [31:0] ex_addr, ex_store_data;
    logic [4:0]  ex_rd;
    logic        stall, dmem_rd_en, dmem_wr_en;
    logic [31:0] dmem_addr, dmem_wr_data, dmem_rd_data;
    logic        wb_valid, wb_regwrite, exc_misalign, exc_range;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.DEPTH_LOG2(5), .CHECK_RANGE(1'b1)) dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_op(ex_op), .ex_addr(ex_addr),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .stall(stall),
        .dmem_addr(dmem_addr), .dmem_rd_en(dmem_rd_en), .dmem_wr_en(dmem_wr_en),
        .dmem_wr_data(dmem_wr_data), .dmem_rd_data(dmem_rd_data), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_data(wb_data),
        .exc_misalign(exc_misalign), .exc_range(exc_range)
    );

    // Word-only data memory with a preload path used while reset is held.
    logic [31:0] mem [32];
    logic        pl_en = 1'b0;
    logic [4:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;
    always @(posedge clk) begin
        if (pl_en)           mem[pl_idx] <= pl_val;
        else if (dmem_wr_en) mem[dmem_addr[6:2]] <= dmem_wr_data;
    end
    assign dmem_rd_data = mem[dmem_addr[6:2]];

    logic [7:0]  ref_bytes [128];
    logic [31:0] last_rmw_word;

    function automatic logic [31:0] z1(input logic b);
        return {31'b0, b};
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_bytes[a+3], ref_bytes[a+2], ref_bytes[a+1], ref_bytes[a]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [31:0] a);
        logic [15:0] h;
        logic [7:0]  b;
        h = {ref_bytes[a+1], ref_bytes[a]};
        b = ref_bytes[a];
        case (op)
            T_LH:    return {{16{h[15]}}, h};
            T_LHU:   return {16'h0, h};
            T_LB:    return {{24{b[7]}}, b};
            T_LBU:   return {24'h0, b};
            default: return ref_word(a);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_stall"}, z1(stall), 0);
        check({tag, "_dmem"}, {dmem_addr | dmem_wr_data} | z1(dmem_rd_en | dmem_wr_en), 0);
        check({tag, "_wb_valid"}, z1(wb_valid), 0);
        check({tag, "_wb_rw"}, z1(wb_regwrite), 0);
        check({tag, "_wb_rd"}, {27'b0, wb_rd}, 0);
        check({tag, "_wb_data"}, wb_data, 0);
        check({tag, "_exc"}, z1(exc_misalign | exc_range), 0);
    endtask

    task automatic check_mem_all();
        for (int i = 0; i < 32; i++) check("mem_word", mem[i], ref_word(32'(i * 4)));
    endtask

    task automatic idle();
        @(negedge clk);
        ex_valid = 1'b0; ex_op = 4'($urandom_range(0, 15)); ex_addr = $urandom;
        ex_regwrite = 1'b1; ex_rd = 5'($urandom);
        #1;
        check("idle_strobes", z1(stall | dmem_rd_en | dmem_wr_en), 0);
        @(posedge clk); #1;
        check("idle_wb_valid", z1(wb_valid), 0);
        check("idle_wb_rw", z1(wb_regwrite), 0);
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd, input logic rw);
        logic [31:0] nb, base, exp_data, exp_word;
        logic is_ld, is_st, is_sub, is_mem, mis, rng, ok, exp_rw;
        is_ld  = (op >= T_LW) && (op <= T_LBU);
        is_st  = (op >= T_SW) && (op <= T_SB);
        is_sub = (op == T_SH) || (op == T_SB);
        is_mem = is_ld || is_st;
        nb     = (op == T_LW || op == T_SW) ? 32'd4 :
                 (op == T_LH || op == T_LHU || op == T_SH) ? 32'd2 : 32'd1;
        mis    = is_mem && ((addr % nb) != 0);
        rng    = is_mem && !mis && (addr >= 32'd128);
        ok     = is_mem && !mis && !rng;
        exp_rw = is_mem ? (ok && is_ld) : rw;
        exp_data = '0; exp_word = '0;
        base = addr & ~32'd3;

        @(negedge clk);
        ex_valid = 1'b1; ex_op = op; ex_addr = addr; ex_store_data = data;
        ex_rd = rd; ex_regwrite = rw;
        #1;
        check("rd_wr_exclusive", z1(dmem_rd_en & dmem_wr_en), 0);
        check("stall", z1(stall), z1(ok && is_sub));
        check("rd_en", z1(dmem_rd_en), z1(ok && (is_ld || is_sub)));
        check("wr_en", z1(dmem_wr_en), z1(ok && op == T_SW));
        if (ok) check("dmem_addr", dmem_addr, addr);
        if (ok && op == T_SW) check("sw_data", dmem_wr_data, data);

        if (ok && is_ld) exp_data = ref_load(op, addr);
        if (ok && is_st) begin
            for (int k = 0; k < 32'(nb); k++) ref_bytes[addr + 32'(k)] = data[8*k +: 8];
            exp_word = ref_word(base);
        end

        if (ok && is_sub) begin
            @(posedge clk); #1;
            check("rmw_stall", z1(stall), 0);
            check("rmw_wr_en", z1(dmem_wr_en), 1);
            check("rmw_rd_en", z1(dmem_rd_en), 0);
            check("rmw_word_idx", {27'b0, dmem_addr[6:2]}, {27'b0, base[6:2]});
            check("rmw_data", dmem_wr_data, exp_word);
            last_rmw_word = dmem_wr_data;
            ex_store_data = ~data;
            #1;
            check("rmw_hold", dmem_wr_data, exp_word);
        end

        @(posedge clk); #1;
        check("wb_valid", z1(wb_valid), 1);
        check("wb_rd", {27'b0, wb_rd}, {27'b0, rd});
        check("wb_regwrite", z1(wb_regwrite), z1(exp_rw));
        if (ok && is_ld) check("wb_load", wb_data, exp_data);
        if (!is_mem)     check("wb_alu", wb_data, addr);
        check("exc_misalign", z1(exc_misalign), z1(mis));
        check("exc_range", z1(exc_range), z1(rng));
    endtask

    initial begin
        logic [31:0] v;
        reset = 1'b1; ex_valid = 1'b0; ex_op = '0; ex_addr = '0; ex_store_data = '0;
        ex_rd = '0; ex_regwrite = 1'b0; last_rmw_word = '0;

        for (int i = 0; i < 32; i++) begin
            v = (i == 0) ? 32'h0232_8021 : (i == 7 || i == 8) ? 32'h0000_000A : $urandom;
            @(negedge clk);
            pl_en = 1'b1; pl_idx = 5'(i); pl_val = v;
            for (int k = 0; k < 4; k++) ref_bytes[i*4 + k] = v[8*k +: 8];
        end
        @(negedge clk); pl_en = 1'b0;
        @(posedge clk); #1;
        check_zero("reset");
        @(negedge clk); reset = 1'b0; #1;
        check_zero("post_reset");

        do_op(T_LW, 32'h1C, 32'h0, 5'd2, 1'b1);
        check("lw_1c_lit", wb_data, 32'h0000_000A);
        do_op(T_LB,  32'h03, 32'h0, 5'd3, 1'b1); check("lb_03_lit",  wb_data, 32'h0000_0002);
        do_op(T_LB,  32'h01, 32'h0, 5'd3, 1'b1); check("lb_01_lit",  wb_data, 32'hFFFF_FF80);
        do_op(T_LBU, 32'h01, 32'h0, 5'd3, 1'b1); check("lbu_01_lit", wb_data, 32'h0000_0080);
        do_op(T_LH,  32'h00, 32'h0, 5'd4, 1'b1); check("lh_00_lit",  wb_data, 32'hFFFF_8021);
        do_op(T_LHU, 32'h00, 32'h0, 5'd4, 1'b1); check("lhu_00_lit", wb_data, 32'h0000_8021);
        do_op(T_LH,  32'h02, 32'h0, 5'd4, 1'b1); check("lh_02_lit",  wb_data, 32'h0000_0232);

        do_op(T_SB, 32'h21, 32'h0000_00FF, 5'd5, 1'b0);
        check("sb_merge_lit", last_rmw_word, 32'h0000_FF0A);
        do_op(T_LW, 32'h20, 32'h0, 5'd6, 1'b1);
        check("lw_20_lit", wb_data, 32'h0000_FF0A);

        do_op(T_LW, 32'h22, 32'h0, 5'd7, 1'b1);
        do_op(T_SH, 32'h05, 32'h1234, 5'd7, 1'b0);
        do_op(T_LH, 32'h03, 32'h0, 5'd7, 1'b1);
        do_op(T_LW, 32'h80, 32'h0, 5'd8, 1'b1);
        do_op(T_SB, 32'h81, 32'h0, 5'd8, 1'b0);
        do_op(T_NOP, 32'hDEAD_BEEF, 32'h0, 5'd9, 1'b1);
        do_op(4'd12, 32'h0000_1234, 32'h0, 5'd10, 1'b0);
        idle();
        check_mem_all();

        // Reset landing in the RMW cycle must cancel the pending write.
        @(negedge clk);
        ex_valid = 1'b1; ex_op = T_SH; ex_addr = 32'h0; ex_store_data = 32'h0000_BEEF;
        ex_rd = 5'd11; ex_regwrite = 1'b0;
        #1 check("abort_stall", z1(stall), 1);
        @(posedge clk); #1;
        reset = 1'b1; #1;
        check("abort_wr_en", z1(dmem_wr_en), 0);
        @(negedge clk);
        ex_valid = 1'b0; ex_op = '0; ex_addr = '0; ex_store_data = '0; ex_rd = '0; ex_regwrite = 1'b0;
        @(posedge clk); #1;
        check_zero("abort_reset");
        @(negedge clk); reset = 1'b0; #1;
        check_zero("abort_after");
        do_op(T_LW, 32'h00, 32'h0, 5'd12, 1'b1);
        check("abort_lw_lit", wb_data, 32'h0232_8021);

        for (int n = 0; n < 200; n++) begin
            int r;
            logic [3:0]  op;
            logic [31:0] a;
            r  = $urandom_range(0, 9);
            op = (r < 8) ? 4'($urandom_range(1, 8)) : 4'($urandom_range(0, 15));
            a  = $urandom_range(0, 127);
            if ($urandom_range(0, 15) == 0) a = a | 32'h0000_1000;
            if (r == 0) idle();
            else do_op(op, a, $urandom, 5'($urandom), 1'($urandom));
        end
        idle();
        check_mem_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
